fetch_stage: RTL and testbench

//  RAPID-X instruction fetch stage; sits directly upstream of decoder_state.
//  - Generates the sequential PC and issues requests to instruction memory over a valid/ready bus.
//  - Buffers in-order responses with their PCs in a small FIFO.
//  - Presents {pc, instruction} to the decoder with a valid/ready handshake.
//  - Handles branch/jump redirects by flushing buffered and in-flight fetches.

---
 rtl/rapid_pkg.sv | 17 +
 rtl/fetch_fifo.sv | 51 +++++
 rtl/fetch_stage.sv | 120 ++++++++++++
 tb/tb_fetch_stage.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rapid_pkg.sv
// Shared RAPID-X front-end types: machine width, fetch FSM states and buffered fetch entries.
package rapid_pkg;
  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            fault;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO (power-of-2 depth) with flush; head is visible combinationally.
// Push while full is accepted only together with a pop; flush wins over push and pop.
module fetch_fifo #(
  parameter type T     = logic [31:0],
  parameter int  DEPTH = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  T                       data_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  output T                       head_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);
  localparam int AW = $clog2(DEPTH);

  T               mem_q [DEPTH];
  logic [AW-1:0]  wr_q, rd_q;
  logic [AW:0]    cnt_q;
  logic           do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_q];
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= wr_q + AW'(1);
      end
      if (do_pop) rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/fetch_stage.sv
// RAPID-X fetch stage: sequential PC, credit-limited imem requests, in-order response buffer, redirect flush.
// Optional RAPID_FETCH_PERF_EN adds saturating decoder-pop and decoder-stall counters.
module fetch_stage
  import rapid_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic            o_imem_req_valid,
  input  logic            i_imem_req_ready,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic            i_imem_resp_valid,
  input  logic [XLEN-1:0] i_imem_resp_data,
  input  logic            i_imem_resp_err,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_instruction,
  output logic            o_fault
`ifdef RAPID_FETCH_PERF_EN
  ,
  output logic [31:0]     o_perf_fetched,
  output logic [31:0]     o_perf_stall
`endif
);
  localparam int             CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0]    DEPTH_C = (CW+1)'(FIFO_DEPTH);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]   discard_q, discard_d;
  logic [CW-1:0]   buf_count, pcq_count;
  logic            buf_full, buf_empty, pcq_full, pcq_empty;
  fetch_entry_t    buf_head, buf_in;
  logic [XLEN-1:0] pcq_head;
  logic [CW:0]     outstanding;
  logic            req_fire, resp_keep, pop_fire;
  logic            unused_flags;

  // Stale requests still owed a response count as outstanding so the PC queue never overflows.
  assign outstanding      = {1'b0, pcq_count} + {1'b0, discard_q};
  assign o_imem_req_valid = (state_q == RUN) && ((outstanding + {1'b0, buf_count}) < DEPTH_C);
  assign o_imem_addr      = fetch_pc_q;
  assign req_fire         = o_imem_req_valid && i_imem_req_ready;
  assign resp_keep        = i_imem_resp_valid && !i_redirect && (discard_q == '0);
  assign pop_fire         = o_valid && i_ready;
  assign buf_in           = '{pc: pcq_head, instr: i_imem_resp_data, fault: i_imem_resp_err};
  assign unused_flags     = ^{buf_full, pcq_full, pcq_empty};

  fetch_fifo #(.T(logic [XLEN-1:0]), .DEPTH(FIFO_DEPTH)) u_pc_queue (
    .clk_i(i_clk), .rst_ni(i_reset),
    .push_i(req_fire && !i_redirect), .data_i(fetch_pc_q),
    .pop_i(resp_keep), .flush_i(i_redirect),
    .head_o(pcq_head), .count_o(pcq_count), .full_o(pcq_full), .empty_o(pcq_empty)
  );

  fetch_fifo #(.T(fetch_entry_t), .DEPTH(FIFO_DEPTH)) u_entry_buf (
    .clk_i(i_clk), .rst_ni(i_reset),
    .push_i(resp_keep), .data_i(buf_in),
    .pop_i(pop_fire), .flush_i(i_redirect),
    .head_o(buf_head), .count_o(buf_count), .full_o(buf_full), .empty_o(buf_empty)
  );

  assign o_valid       = !buf_empty;
  assign o_pc          = buf_head.pc;
  assign o_instruction = buf_head.instr;
  assign o_fault       = buf_head.fault;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    discard_d  = discard_q;
    if (i_redirect) begin
      state_d    = RUN;
      fetch_pc_d = i_redirect_pc;
      discard_d  = CW'(outstanding + (CW+1)'(req_fire) - (CW+1)'(i_imem_resp_valid));
    end else begin
      case (state_q)
        IDLE:    state_d = RUN;
        RUN:     if (resp_keep && i_imem_resp_err) state_d = HALT;
        default: state_d = state_q;
      endcase
      if (req_fire) fetch_pc_d = fetch_pc_q + XLEN'(INSTR_BYTES);
      if (i_imem_resp_valid && (discard_q != '0)) discard_d = discard_q - CW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      discard_q  <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      discard_q  <= discard_d;
    end
  end

`ifdef RAPID_FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_stall_q;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      perf_fetched_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      if (pop_fire && (perf_fetched_q != '1)) perf_fetched_q <= perf_fetched_q + 32'd1;
      if (o_valid && !i_ready && (perf_stall_q != '1)) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign o_perf_fetched = perf_fetched_q;
  assign o_perf_stall   = perf_stall_q;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: fixed-delay in-order memory model, scoreboard of accepted fetches, scenario table.
`timescale 1ns/1ps
module tb_fetch_stage;
  import rapid_pkg::*;

  logic i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  logic i_reset, i_redirect, i_imem_req_ready, i_imem_resp_valid, i_imem_resp_err, i_ready;
  logic [31:0] i_redirect_pc, i_imem_resp_data;
  logic o_imem_req_valid, o_valid, o_fault;
  logic [31:0] o_imem_addr, o_pc, o_instruction;

  logic w_reset, w_redirect, w_req_ready, w_resp_valid, w_resp_err, w_ready;
  logic [31:0] w_redirect_pc, w_resp_data;
  logic w_req_valid, w_valid, w_fault;
  logic [31:0] w_addr, w_pc, w_instruction;

`ifdef RAPID_FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_stall, w_perf_fetched, w_perf_stall;
`endif

  fetch_stage #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
    .o_imem_req_valid(o_imem_req_valid), .i_imem_req_ready(i_imem_req_ready), .o_imem_addr(o_imem_addr),
    .i_imem_resp_valid(i_imem_resp_valid), .i_imem_resp_data(i_imem_resp_data),
    .i_imem_resp_err(i_imem_resp_err), .o_valid(o_valid), .i_ready(i_ready), .o_pc(o_pc),
    .o_instruction(o_instruction), .o_fault(o_fault)
`ifdef RAPID_FETCH_PERF_EN
    , .o_perf_fetched(perf_fetched), .o_perf_stall(perf_stall)
`endif
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .FIFO_DEPTH(2)) dut_wrap (
    .i_clk(i_clk), .i_reset(w_reset), .i_redirect(w_redirect), .i_redirect_pc(w_redirect_pc),
    .o_imem_req_valid(w_req_valid), .i_imem_req_ready(w_req_ready), .o_imem_addr(w_addr),
    .i_imem_resp_valid(w_resp_valid), .i_imem_resp_data(w_resp_data),
    .i_imem_resp_err(w_resp_err), .o_valid(w_valid), .i_ready(w_ready), .o_pc(w_pc),
    .o_instruction(w_instruction), .o_fault(w_fault)
`ifdef RAPID_FETCH_PERF_EN
    , .o_perf_fetched(w_perf_fetched), .o_perf_stall(w_perf_stall)
`endif
  );

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  typedef struct { logic [31:0] pc; logic [31:0] ins; logic f; } exp_t;
  typedef struct { int dly; int first_lat; logic [31:0] pc0, pc1, pc2, pc3; } vec_t;

  mreq_t       mq[$];
  exp_t        sb[$];
  logic [31:0] popped[$];
  logic [31:0] w_popped[$];
  logic [31:0] w_popped_ins[$];
  logic [31:0] exp_fetch, err_addr;
  bit          err_en;
  int          cyc, dly, acc_cnt;
  int          n_checks = 0;
  int          n_pass = 0;
  vec_t        vt[3];

  function automatic logic [31:0] img(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: event missing or timed out", name);
  endtask

  task automatic check_pop(input string name, input int idx, input logic [31:0] exp);
    if (idx < popped.size()) check(name, popped[idx], exp);
    else fail_now(name);
  endtask

  // One clock of the main DUT: scoreboard pop/flush/push, then the memory model drives responses.
  task automatic tick();
    bit acc, pop, redir;
    logic [31:0] a;
    exp_t e;
    mreq_t m;
    #1;
    acc   = o_imem_req_valid && i_imem_req_ready;
    pop   = o_valid && i_ready;
    redir = i_redirect;
    a     = o_imem_addr;
    if (pop) begin
      popped.push_back(o_pc);
      if (sb.size() == 0) fail_now("sb_unexpected_pop");
      else begin
        e = sb.pop_front();
        check("sb_pc", o_pc, e.pc);
        check("sb_instr", o_instruction, e.ins);
        check("sb_fault", 32'(o_fault), 32'(e.f));
      end
    end
    if (redir) begin
      sb.delete();
      exp_fetch = i_redirect_pc;
    end else if (acc) begin
      check("fetch_addr", a, exp_fetch);
      exp_fetch = exp_fetch + 32'd4;
      e.pc = a; e.ins = img(a); e.f = err_en && (a == err_addr);
      sb.push_back(e);
    end
    if (acc) begin
      acc_cnt++;
      m.addr = a; m.due = cyc + dly;
      mq.push_back(m);
    end
    @(posedge i_clk); #1;
    cyc++;
    i_redirect = 1'b0;
    if (mq.size() > 0 && mq[0].due == cyc) begin
      m = mq.pop_front();
      i_imem_resp_valid = 1'b1;
      i_imem_resp_data  = img(m.addr);
      i_imem_resp_err   = err_en && (m.addr == err_addr);
    end else begin
      i_imem_resp_valid = 1'b0;
      i_imem_resp_data  = '0;
      i_imem_resp_err   = 1'b0;
    end
  endtask

  task automatic run_pops(input int n, input int budget);
    int k;
    k = 0;
    while (popped.size() < n && k < budget) begin tick(); k++; end
    if (popped.size() < n) fail_now("pop_budget");
  endtask

  task automatic do_reset(input bit chk);
    i_reset = 1'b0; i_redirect = 1'b0; i_redirect_pc = '0;
    i_imem_resp_valid = 1'b0; i_imem_resp_data = '0; i_imem_resp_err = 1'b0;
    err_en = 1'b0; mq.delete(); sb.delete(); popped.delete(); acc_cnt = 0;
    repeat (2) @(posedge i_clk);
    #1;
    if (chk) begin
      check("rst_valid", 32'(o_valid), 32'd0);
      check("rst_req_valid", 32'(o_imem_req_valid), 32'd0);
      check("rst_pc", o_pc, 32'd0);
      check("rst_instr", o_instruction, 32'd0);
      check("rst_fault", 32'(o_fault), 32'd0);
      check("rst_addr", o_imem_addr, 32'd0);
    end
    exp_fetch = 32'h0; cyc = 0;
    i_reset = 1'b1;
  endtask

  task automatic w_tick();
    bit acc;
    logic [31:0] a;
    #1;
    acc = w_req_valid && w_req_ready;
    a   = w_addr;
    if (w_valid && w_ready) begin
      w_popped.push_back(w_pc);
      w_popped_ins.push_back(w_instruction);
    end
    @(posedge i_clk); #1;
    w_resp_valid = acc;
    w_resp_data  = acc ? img(a) : '0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k, bad;
    logic [31:0] hold_pc, hold_ins;
    vt[0] = '{1, 3, 32'h0, 32'h4, 32'h8, 32'hC};
    vt[1] = '{2, 4, 32'h0, 32'h4, 32'h8, 32'hC};
    vt[2] = '{3, 5, 32'h0, 32'h4, 32'h8, 32'hC};

    i_reset = 1'b1; i_redirect = 1'b0; i_redirect_pc = '0; i_imem_req_ready = 1'b1;
    i_imem_resp_valid = 1'b0; i_imem_resp_data = '0; i_imem_resp_err = 1'b0; i_ready = 1'b1;
    w_reset = 1'b1; w_redirect = 1'b0; w_redirect_pc = '0; w_req_ready = 1'b1;
    w_resp_valid = 1'b0; w_resp_data = '0; w_resp_err = 1'b0; w_ready = 1'b1;
    err_addr = 32'h8; err_en = 1'b0; dly = 1;
    #2;
    i_reset = 1'b0; w_reset = 1'b0;

    // Streaming from reset across memory delays.
    for (int r = 0; r < 3; r++) begin
      dly = vt[r].dly;
      do_reset(r == 0);
      check("idle_no_req", 32'(o_imem_req_valid), 32'd0);
      k = 0;
      while (!o_valid && k < 40) begin tick(); k++; end
      check("first_valid_latency", 32'(cyc), 32'(vt[r].first_lat));
      run_pops(4, 80);
      check_pop("stream_pc0", 0, vt[r].pc0);
      check_pop("stream_pc1", 1, vt[r].pc1);
      check_pop("stream_pc2", 2, vt[r].pc2);
      check_pop("stream_pc3", 3, vt[r].pc3);
    end

    // Decoder stall: buffer fills to depth, head holds, requests stop, then resume without loss.
    dly = 1;
    do_reset(1'b0);
    i_ready = 1'b0;
    k = 0;
    while (!o_valid && k < 40) begin tick(); k++; end
    hold_pc = o_pc; hold_ins = o_instruction; bad = 0;
    repeat (10) begin
      tick();
      if (!o_valid || o_pc !== hold_pc || o_instruction !== hold_ins) bad++;
    end
    check("stall_hold_stable", 32'(bad), 32'd0);
    check("stall_hold_pc", hold_pc, 32'h0);
    check("stall_accepts", 32'(acc_cnt), 32'd2);
    check("stall_no_req", 32'(o_imem_req_valid), 32'd0);
    i_ready = 1'b1;
    run_pops(4, 60);
    for (int i = 0; i < 4; i++) check_pop("resume_pc", i, 32'(4 * i));

    // Redirect with two slow fetches in flight.
    dly = 3;
    do_reset(1'b0);
    repeat (3) tick();
    check("two_inflight", 32'(acc_cnt), 32'd2);
    popped.delete();
    i_redirect = 1'b1; i_redirect_pc = 32'h100;
    tick();
    check("redir_addr", o_imem_addr, 32'h100);
    run_pops(2, 60);
    check_pop("redir_pc0", 0, 32'h100);
    check_pop("redir_pc1", 1, 32'h104);

    // Redirect coinciding with a response and an accepted request.
    dly = 1;
    do_reset(1'b0);
    k = 0;
    while (!(o_imem_req_valid && i_imem_req_ready && i_imem_resp_valid) && k < 20) begin tick(); k++; end
    if (k >= 20) fail_now("coincide_search");
    popped.delete();
    i_redirect = 1'b1; i_redirect_pc = 32'h200;
    tick();
    check("coincide_addr", o_imem_addr, 32'h200);
    check("coincide_valid_low", 32'(o_valid), 32'd0);
    run_pops(1, 40);
    check_pop("coincide_pc0", 0, 32'h200);

    // Access fault halts fetching until a redirect.
    do_reset(1'b0);
    err_en = 1'b1; err_addr = 32'h8;
    k = 0;
    while (!(o_valid && o_fault) && k < 40) begin tick(); k++; end
    check("fault_seen", 32'(o_valid && o_fault), 32'd1);
    check("fault_pc", o_pc, 32'h8);
    bad = 0;
    repeat (10) begin tick(); if (o_imem_req_valid) bad++; end
    check("halt_no_req", 32'(bad), 32'd0);
    err_en = 1'b0;
    popped.delete();
    i_redirect = 1'b1; i_redirect_pc = 32'h0;
    tick();
    run_pops(2, 40);
    check_pop("resume_after_fault0", 0, 32'h0);
    check_pop("resume_after_fault1", 1, 32'h4);
    i_reset = 1'b0;

    // Wrapping reset PC and asynchronous reset mid-stream.
    @(posedge i_clk); #1;
    w_reset = 1'b1;
    k = 0;
    while (w_popped.size() < 2 && k < 40) begin w_tick(); k++; end
    if (w_popped.size() >= 2) begin
      check("wrap_pc0", w_popped[0], 32'hFFFF_FFFC);
      check("wrap_instr0", w_popped_ins[0], img(32'hFFFF_FFFC));
      check("wrap_pc1", w_popped[1], 32'h0);
    end else fail_now("wrap_pops");
    k = 0;
    while (!w_valid && k < 20) begin w_tick(); k++; end
    check("wrap_midstream_valid", 32'(w_valid), 32'd1);
    #2;
    w_reset = 1'b0;
    #1;
    check("async_rst_valid", 32'(w_valid), 32'd0);
    check("async_rst_req", 32'(w_req_valid), 32'd0);
    check("async_rst_pc", w_pc, 32'd0);
    check("async_rst_instr", w_instruction, 32'd0);
    check("async_rst_fault", 32'(w_fault), 32'd0);
    @(posedge i_clk); #1;
    w_resp_valid = 1'b0; w_resp_data = '0;
    w_popped.delete(); w_popped_ins.delete();
    w_reset = 1'b1;
    k = 0;
    while (w_popped.size() < 1 && k < 40) begin w_tick(); k++; end
    if (w_popped.size() >= 1) check("restart_pc", w_popped[0], 32'hFFFF_FFFC);
    else fail_now("restart_pop");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
